// File: rtl/vga_timing_if.sv
// Video timing output bundle for vga_timing_gen.
// Look-ahead members exist only with VGA_LOOKAHEAD_EN.
`timescale 1ns/1ps
interface vga_timing_if #(
  parameter int CW = 10
);
  logic          VGA_HS;
  logic          VGA_VS;
  logic          valid;
  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_LOOKAHEAD_EN
  logic          next_valid;
  logic [CW-1:0] NX;
  logic [CW-1:0] NY;

  modport master (
    output VGA_HS, VGA_VS, valid, X, Y,
    output line_start, frame_start,
    output next_valid, NX, NY
  );
  modport slave (
    input VGA_HS, VGA_VS, valid, X, Y,
    input line_start, frame_start,
    input next_valid, NX, NY
  );
`else
  modport master (
    output VGA_HS, VGA_VS, valid, X, Y,
    output line_start, frame_start
  );
  modport slave (
    input VGA_HS, VGA_VS, valid, X, Y,
    input line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync / pixel position generator, registered outputs.
// Optional VGA_LOOKAHEAD_EN adds next_valid/NX/NY one enabled edge ahead.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic       VGA_CLK,
  input  logic       RST_N,
  input  logic       EN,
  vga_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CW < 1 || CW > 30 ||
      H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_params
    $error("vga_timing_gen: invalid timing parameters");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          vld;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
  } dec_t;

  localparam dec_t DEC_RST = '{
    hs: ~HS_POL, vs: ~VS_POL, vld: 1'b0,
    x: '0, y: '0, ls: 1'b0, fs: 1'b0
  };

  function automatic dec_t decode(
    input logic [CW-1:0] h,
    input logic [CW-1:0] v
  );
    dec_t d;
    logic act;
    act   = (h < H_ACT) && (v < V_ACT);
    d.vld = act;
    d.x   = act ? h : '0;
    d.y   = act ? v : '0;
    d.hs  = (h >= HS_BEG && h < HS_END) ? HS_POL : ~HS_POL;
    d.vs  = (v >= VS_BEG && v < VS_END) ? VS_POL : ~VS_POL;
    d.ls  = (h == '0);
    d.fs  = (h == '0) && (v == '0);
    return d;
  endfunction

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          h_end, v_end;
  dec_t          out_q;

  assign h_end = (h_q == H_LAST);
  assign v_end = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    unique case (1'b1)
      !h_end: h_d = h_q + 1'b1;
      h_end && !v_end: begin
        h_d = '0;
        v_d = v_q + 1'b1;
      end
      default: begin
        h_d = '0;
        v_d = '0;
      end
    endcase
  end

  // Outputs decode the pre-advance counter: one enabled edge of latency.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_q   <= '0;
      v_q   <= '0;
      out_q <= DEC_RST;
    end else if (EN) begin
      h_q   <= h_d;
      v_q   <= v_d;
      out_q <= decode(h_q, v_q);
    end
  end

  assign vid.VGA_HS      = out_q.hs;
  assign vid.VGA_VS      = out_q.vs;
  assign vid.valid       = out_q.vld;
  assign vid.X           = out_q.x;
  assign vid.Y           = out_q.y;
  assign vid.line_start  = out_q.ls;
  assign vid.frame_start = out_q.fs;

`ifdef VGA_LOOKAHEAD_EN
  logic          la_act_d;
  logic          nvld_q;
  logic [CW-1:0] nx_q, ny_q;

  assign la_act_d = (h_d < H_ACT) && (v_d < V_ACT);

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      nvld_q <= 1'b0;
      nx_q   <= '0;
      ny_q   <= '0;
    end else if (EN) begin
      nvld_q <= la_act_d;
      nx_q   <= la_act_d ? h_d : '0;
      ny_q   <= la_act_d ? v_d : '0;
    end
  end

  assign vid.next_valid = nvld_q;
  assign vid.NX         = nx_q;
  assign vid.NY         = ny_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 and a tiny 14x7 instance.
// Position model plus directed literal checks on both.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  bit   chk_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  longint cnt = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(10)) d_if ();
  vga_timing_if #(.CW(4))  s_if ();

  vga_timing_gen u_dflt (
    .VGA_CLK (clk),
    .RST_N   (rst_n),
    .EN      (en),
    .vid     (d_if)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
  ) u_small (
    .VGA_CLK (clk),
    .RST_N   (rst_n),
    .EN      (en),
    .vid     (s_if)
  );

  typedef struct {
    bit hs; bit vs; bit vld;
    int x;  int y;
    bit ls; bit fs;
  } exp_t;

  // cnt = enabled edges since reset; edge n shows raster position n-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (en) cnt <= cnt + 1;
  end

  function automatic exp_t mdl(
    input longint c,
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb,
    input bit hp, input bit vp
  );
    exp_t e;
    longint ht, vt, p;
    int h, v;
    e = '{hs: !hp, vs: !vp, vld: 0, x: 0, y: 0, ls: 0, fs: 0};
    if (c == 0) return e;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = (c - 1) % (ht * vt);
    h  = int'(p % ht);
    v  = int'(p / ht);
    e.vld = (h < ha) && (v < va);
    e.x   = e.vld ? h : 0;
    e.y   = e.vld ? v : 0;
    e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t a, input exp_t w);
    n_cmp++;
    if (a.hs != w.hs || a.vs != w.vs || a.vld != w.vld ||
        a.x != w.x || a.y != w.y || a.ls != w.ls || a.fs != w.fs) begin
      n_bad++;
      $display("FAIL %s cnt=%0d got hs%0b vs%0b v%0b x%0d y%0d ls%0b fs%0b want hs%0b vs%0b v%0b x%0d y%0d ls%0b fs%0b",
               nm, cnt, a.hs, a.vs, a.vld, a.x, a.y, a.ls, a.fs,
               w.hs, w.vs, w.vld, w.x, w.y, w.ls, w.fs);
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      exp_t a;
      exp_t w;
      a = '{hs: d_if.VGA_HS, vs: d_if.VGA_VS, vld: d_if.valid,
            x: int'(d_if.X), y: int'(d_if.Y),
            ls: d_if.line_start, fs: d_if.frame_start};
      cmp("dflt_cycle", a, mdl(cnt, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0));
      a = '{hs: s_if.VGA_HS, vs: s_if.VGA_VS, vld: s_if.valid,
            x: int'(s_if.X), y: int'(s_if.Y),
            ls: s_if.line_start, fs: s_if.frame_start};
      w = mdl(cnt, 8, 2, 3, 1, 4, 1, 1, 1, 1, 0);
      cmp("small_cycle", a, w);
`ifdef VGA_LOOKAHEAD_EN
      w = mdl(cnt + 1, 8, 2, 3, 1, 4, 1, 1, 1, 1, 0);
      if (cnt == 0) w = '{hs: 0, vs: 0, vld: 0, x: 0, y: 0, ls: 0, fs: 0};
      n_cmp++;
      if (s_if.next_valid != w.vld || int'(s_if.NX) != w.x ||
          int'(s_if.NY) != w.y) begin
        n_bad++;
        $display("FAIL small_lookahead cnt=%0d got v%0b nx%0d ny%0d want v%0b nx%0d ny%0d",
                 cnt, s_if.next_valid, s_if.NX, s_if.NY, w.vld, w.x, w.y);
      end
`endif
    end
  end

  int  vcnt = 0, hs_first = -1, hs_len = 0, ls2 = -1;
  int  s_fs2 = -1, s_vs_first = -1, s_vs_len = 0;
  int  s_hs_first = -1, s_hs_len = 0, s_ls2 = -1, s_ymax = 0;
  bit  found = 0;

  initial begin
    #100;
    chk("rst_valid", d_if.valid, 0);
    chk("rst_x", d_if.X, 0);
    chk("rst_y", d_if.Y, 0);
    chk("rst_hs", d_if.VGA_HS, 1);
    chk("rst_vs", d_if.VGA_VS, 1);
    chk("rst_ls", d_if.line_start, 0);
    chk("rst_fs", d_if.frame_start, 0);
    chk("rst_small_hs", s_if.VGA_HS, 0);
    #95;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("first_valid", d_if.valid, 1);
    chk("first_x", d_if.X, 0);
    chk("first_y", d_if.Y, 0);
    chk("first_fs", d_if.frame_start, 1);
    chk("first_ls", d_if.line_start, 1);
    chk("first_hs", d_if.VGA_HS, 1);
    chk("first_vs", d_if.VGA_VS, 1);

    for (int k = 1; k <= 1700; k++) begin
      if (d_if.valid && d_if.Y == 0) vcnt++;
      if (!d_if.VGA_HS && hs_first < 0) hs_first = k;
      if (!d_if.VGA_HS && k <= 800) hs_len++;
      if (d_if.line_start && k > 1 && ls2 < 0) ls2 = k;
      if (s_if.frame_start && k > 1 && s_fs2 < 0) s_fs2 = k;
      if (!s_if.VGA_VS && s_vs_first < 0) s_vs_first = k;
      if (!s_if.VGA_VS && k <= 98) s_vs_len++;
      if (s_if.VGA_HS && s_hs_first < 0) s_hs_first = k;
      if (s_if.VGA_HS && k <= 14) s_hs_len++;
      if (s_if.line_start && k > 1 && s_ls2 < 0) s_ls2 = k;
      if (s_if.valid && int'(s_if.Y) > s_ymax) s_ymax = int'(s_if.Y);
      @(negedge clk);
    end
    chk("valid_len", vcnt, 640);
    chk("hs_offset", hs_first - 1, 656);
    chk("hs_len", hs_len, 96);
    chk("ls_period", ls2 - 1, 800);
    chk("s_fs_period", s_fs2 - 1, 98);
    chk("s_vs_offset", s_vs_first - 1, 70);
    chk("s_vs_len", s_vs_len, 14);
    chk("s_hs_offset", s_hs_first - 1, 10);
    chk("s_hs_len", s_hs_len, 3);
    chk("s_ls_period", s_ls2 - 1, 14);
    chk("s_ymax", s_ymax, 3);

    for (int i = 0; i < 2000; i++) begin
      if (d_if.X == 10'd100 && d_if.Y == 10'd2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("find_x100", found, 1);
    en = 1'b0;
    repeat (50) @(negedge clk);
    chk("stall_x", d_if.X, 100);
    chk("stall_valid", d_if.valid, 1);
    en = 1'b1;
    @(negedge clk);
    chk("resume_x", d_if.X, 101);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", d_if.valid, 0);
    chk("arst_x", d_if.X, 0);
    chk("arst_y", d_if.Y, 0);
    chk("arst_hs", d_if.VGA_HS, 1);
    chk("arst_vs", d_if.VGA_VS, 1);
    chk("arst_small_valid", s_if.valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_x", d_if.X, 0);
    chk("restart_y", d_if.Y, 0);
    chk("restart_fs", d_if.frame_start, 1);
    repeat (300) @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Produces HS/VS, active-video flag, pixel X/Y, and line/frame start strobes from one pixel clock.
- All four porch/sync intervals and both sync polarities are parameters, plus a run enable.
- Sits between the pixel-clock source and the pattern/rectangle renderers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of VGA_HS (0 = active-low)
- VS_POL, 0, asserted level of VGA_VS
- CW, 10, counter and X/Y width; H_TOTAL-1 and V_TOTAL-1 must fit in CW bits

Ports:
- VGA_CLK, in, 1, pixel clock; all logic is on the rising edge
- RST_N, in, 1, asynchronous active-low reset
- EN, in, 1, run enable; when low, counters and outputs hold
- VGA_HS, out, 1, horizontal sync
- VGA_VS, out, 1, vertical sync
- valid, out, 1, high in the active region
- X, out, CW, pixel column while valid, else 0
- Y, out, CW, pixel row while valid, else 0
- line_start, out, 1, one-cycle strobe at Count_H==0
- frame_start, out, 1, one-cycle strobe at Count_H==0 and Count_V==0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default).
- Internal counters Count_H in 0..H_TOTAL-1 and Count_V in 0..V_TOTAL-1; both CW bits.
- Region order per axis: active, front porch, sync, back porch.
- Counter update when EN=1:
  - Count_H increments each cycle.
  - At Count_H==H_TOTAL-1, Count_H wraps to 0 and Count_V increments.
  - At Count_V==V_TOTAL-1 on that same wrap, Count_V wraps to 0.
- Counter and output hold when EN=0:
  - Counters and all output registers hold their values.
  - Strobes also hold, so a strobe may stay high for several cycles while stalled.
- All outputs are registered decodes of the current counter value: fixed latency of 1 enabled clock between counter state and outputs.
- Decodes for counter state (h, v):
  - valid = (h < H_ACTIVE) and (v < V_ACTIVE)
  - X = valid ? h : 0; Y = valid ? v : 0
  - HS asserted (=HS_POL) when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - VS asserted (=VS_POL) when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; VS edges therefore align to h==0
  - line_start = (h==0); frame_start = (h==0 and v==0)
- Reset (RST_N low, asynchronous, may occur mid-frame):
  - Count_H=0, Count_V=0
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL
  - valid=0, X=0, Y=0, line_start=0, frame_start=0
- After reset release, the first enabled edge shows state (0,0): valid=1, X=0, Y=0, line_start=1, frame_start=1.
- No output glitches: every output is driven directly from a flop.
- Invalid parameter sets (any width 0, or totals overflowing CW) are rejected at elaboration with a $error in a generate check.

Optional Feature:
- Macro: VGA_LOOKAHEAD_EN.
- When defined, adds outputs next_valid (1), NX (CW) and NY (CW).
  - These are the decode of the counter value that the main outputs will show on the next enabled edge, i.e. one cycle ahead of valid/X/Y.
  - Purpose: a synchronous pixel RAM read issued on NX/NY returns data aligned with valid.
  - Reset values: next_valid=0, NX=0, NY=0.
  - On wrap, NX/NY follow the wrapped counter: after (639,479) active, the next active look-ahead is (0,0) of the following frame.
- When undefined, these ports and their logic do not exist; the remaining behaviour is identical.

Test Plan:
- Default params: RST_N low 200 ns, then high with EN=1 -> first edge gives valid=1, X=0, Y=0, frame_start=1, HS=1, VS=1; valid falls after exactly 640 cycles.
- Free run one line -> HS low for exactly 96 cycles, starting 656 cycles after line_start; line_start period is 800 cycles.
- Free run two frames -> frame_start period is 420000 cycles; VS low for 1600 cycles starting 490*800 cycles after frame_start; Y reaches 479 and is never above it.
- EN=0 for 50 cycles mid-line at X=100 -> all outputs frozen; at resume X=101 on the next edge.
- RST_N pulsed low mid-frame at Y=200 -> outputs go to reset values immediately without a clock; restart at (0,0).
- Params H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, CW=4 -> HS high at h=10..12, period 14; frame 98 cycles. With VGA_LOOKAHEAD_EN, NX leads X by one cycle throughout.
